// File: rtl/l2_burst_adapter.sv
// rtl/l2_burst_adapter.sv - L2 line <-> 64-bit burst memory adapter
// Collects BEATS memory beats into one fill line, or serialises one writeback line into beats.
module l2_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  line_read_i,
    input  logic                  line_write_i,
    input  logic [ADDR_WIDTH-1:0] line_addr_i,
    input  logic [LINE_WIDTH-1:0] line_wdata_i,
    output logic [LINE_WIDTH-1:0] line_rdata_o,
    output logic                  line_resp_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BEAT_WIDTH-1:0] mem_wdata_o,
    input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_resp_i
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] aligned_addr;

    assign aligned_addr = {line_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // A writeback wins over a simultaneous fill; the fill stays requested and is taken next.
                if (line_write_i) begin
                    addr_d  = aligned_addr;
                    buf_d   = line_wdata_i;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (line_read_i) begin
                    addr_d  = aligned_addr;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (mem_resp_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RD_BURST: begin
                if (mem_resp_i) begin
                    buf_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata_i;
                    if (cnt_q == LAST_BEAT) begin
                        // Publish the whole line at once so no partial fill is ever visible.
                        rdata_d = buf_d;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_read_o   = (state_q == RD_BURST);
    assign mem_write_o  = (state_q == WR_BURST);
    assign mem_addr_o   = (mem_read_o || mem_write_o) ? addr_q : '0;
    assign mem_wdata_o  = mem_write_o ? buf_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign line_resp_o  = (state_q == DONE);
    assign line_rdata_o = rdata_q;
endmodule

// File: tb/tb_l2_burst_adapter.sv
// tb/tb_l2_burst_adapter.sv - self-checking bench for l2_burst_adapter
// Transaction-level model (beat queues) compared every cycle, plus literal directed checks.
module tb_l2_burst_adapter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         line_read, line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata, line_rdata;
    logic         line_resp, mem_read, mem_write, mem_resp;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata, mem_rdata;

    l2_burst_adapter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .line_read_i(line_read), .line_write_i(line_write),
        .line_addr_i(line_addr), .line_wdata_i(line_wdata),
        .line_rdata_o(line_rdata), .line_resp_o(line_resp),
        .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural model: a write is four queued beats drained by mem_resp; a fill collects four beats.
    logic [63:0]  wq[$];
    logic [63:0]  rq[$];
    bit           m_wr, m_rd, m_done;
    logic [31:0]  m_addr;
    logic [255:0] m_rdata;

    initial begin
        m_wr = 0; m_rd = 0; m_done = 0; m_addr = 0; m_rdata = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                wq.delete(); rq.delete();
                m_wr = 0; m_rd = 0; m_done = 0; m_addr = 0; m_rdata = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_wr) begin
                if (mem_resp) begin
                    wq.delete(0);
                    if (wq.size() == 0) begin m_wr = 0; m_done = 1; end
                end
            end else if (m_rd) begin
                if (mem_resp) begin
                    rq.push_back(mem_rdata);
                    if (rq.size() == 4) begin
                        m_rdata = {rq[3], rq[2], rq[1], rq[0]};
                        rq.delete();
                        m_rd = 0; m_done = 1;
                    end
                end
            end else if (line_write) begin
                m_addr = line_addr & ~32'h1f;
                for (int i = 0; i < 4; i++) wq.push_back(line_wdata[i*64 +: 64]);
                m_wr = 1;
            end else if (line_read) begin
                m_addr = line_addr & ~32'h1f;
                m_rd = 1;
            end
        end
    end

    // Compare process plus observation logs used by the directed checks.
    logic [63:0] wlog[$];
    int          resp_cnt = 0;
    int          rbeats = 0;
    int          first_op = 0;

    initial begin
        logic [98:0] exp_ctl;
        forever begin
            @(negedge clk);
            exp_ctl = {m_rd, m_wr, m_done, (m_wr || m_rd) ? m_addr : 32'h0, m_wr ? wq[0] : 64'h0};
            chk("mem_ctl", {mem_read, mem_write, line_resp, mem_addr, mem_wdata}, exp_ctl);
            chk("line_rdata", line_rdata, m_rdata);
            if (mem_write && mem_resp) wlog.push_back(mem_wdata);
            if (mem_read && mem_resp) rbeats++;
            if (line_resp) resp_cnt++;
            if (first_op == 0 && (mem_write || mem_read)) first_op = mem_write ? 1 : 2;
        end
    end

    // Memory responder: 0 random (with spurious idle responses), 1 always ready, 2 three-cycle stalls.
    int          mode = 1;
    int          stall = 0;
    logic [63:0] dq[$];

    initial begin
        bit go;
        mem_resp = 0; mem_rdata = 0;
        forever begin
            @(posedge clk); #2;
            go = 0;
            if (rst_n) begin
                case (mode)
                    0: go = (mem_read || mem_write) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 25);
                    1: go = mem_read || mem_write;
                    default: begin
                        if (mem_read || mem_write) begin
                            if (stall == 3) begin go = 1; stall = 0; end
                            else stall++;
                        end else stall = 0;
                    end
                endcase
            end
            mem_resp = go;
            if (go && mem_read && dq.size() > 0) mem_rdata = dq.pop_front();
            else mem_rdata = {$urandom, $urandom};
        end
    end

    bit          seen_valid;
    logic [31:0] seen_addr;

    task automatic wait_resp(input bit scr, output int cyc);
        bit got = 0;
        cyc = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            cyc++;
            if (!seen_valid && (mem_read || mem_write)) begin seen_valid = 1; seen_addr = mem_addr; end
            if (scr) begin line_addr = $urandom; line_wdata = rand256(); end
            if (line_resp === 1'b1) begin got = 1; break; end
        end
        chk("resp_timeout", got, 1);
    endtask

    task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] wd, input bit scr, output int cyc);
        int c2;
        line_addr = addr; line_wdata = wd; line_read = rd; line_write = wr;
        seen_valid = 0;
        wait_resp(scr, cyc);
        if (rd && wr) begin
            line_write = 0;
            wait_resp(scr, c2);
        end
        line_read = 0; line_write = 0;
        repeat (2) begin @(posedge clk); #2; end
    endtask

    localparam logic [255:0] FILL1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WB1 = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                    64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};

    initial begin
        int cyc, rc0, kind;
        logic [255:0] wd, expl;
        rst_n = 0; line_read = 0; line_write = 0; line_addr = 0; line_wdata = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("reset_ctl", {mem_read, mem_write, line_resp, mem_addr, mem_wdata}, 0);
        chk("reset_rdata", line_rdata, 0);
        @(posedge clk); #2;

        // Directed fill: alignment, beat order and minimum latency.
        mode = 1;
        dq = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        rc0 = resp_cnt;
        run_req(1, 0, 32'h0000_1234, 0, 0, cyc);
        chk("fill_addr", seen_addr, 32'h0000_1220);
        chk("fill_latency", cyc, 6);
        chk("fill_rdata", line_rdata, FILL1);
        chk("fill_resp_count", resp_cnt - rc0, 1);

        // Directed stalled writeback; fill data must survive it.
        mode = 2;
        wlog.delete();
        rc0 = resp_cnt;
        run_req(0, 1, 32'h0000_ABCD, WB1, 0, cyc);
        chk("wb_beats", wlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("wb_beat", (i < wlog.size()) ? wlog[i] : 64'hx, WB1[i*64 +: 64]);
        chk("wb_addr", seen_addr, 32'h0000_ABC0);
        chk("wb_resp_count", resp_cnt - rc0, 1);
        chk("wb_rdata_kept", line_rdata, FILL1);

        // Simultaneous read and write: writeback first, then the fill.
        mode = 1;
        wd = rand256();
        dq = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
               64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
        wlog.delete();
        first_op = 0;
        rc0 = resp_cnt;
        run_req(1, 1, 32'h8000_0040, wd, 0, cyc);
        chk("both_first_op", first_op, 1);
        chk("both_resp_count", resp_cnt - rc0, 2);
        chk("both_wb_beats", wlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("both_wb_beat", (i < wlog.size()) ? wlog[i] : 64'hx, wd[i*64 +: 64]);
        chk("both_rdata", line_rdata, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                       64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});

        // Reset in the middle of a fill abandons it without a response.
        dq = '{64'h5555_5555_5555_5555, 64'h5656_5656_5656_5656,
               64'h5757_5757_5757_5757, 64'h5858_5858_5858_5858};
        rbeats = 0;
        rc0 = resp_cnt;
        line_addr = 32'h0000_2000; line_read = 1;
        for (int i = 0; i < 50 && rbeats < 2; i++) begin @(posedge clk); #2; end
        chk("mid_reset_beats", rbeats, 2);
        #2 rst_n = 0;
        #1;
        chk("mid_reset_ctl", {mem_read, mem_write, line_resp, mem_addr, mem_wdata}, 0);
        chk("mid_reset_rdata", line_rdata, 0);
        line_read = 0;
        dq.delete();
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); #2;
        chk("mid_reset_no_resp", resp_cnt - rc0, 0);
        dq = '{64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777,
               64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999};
        run_req(1, 0, 32'h4000_005F, 0, 0, cyc);
        chk("refill_latency", cyc, 6);
        chk("refill_addr", seen_addr, 32'h4000_0040);
        chk("refill_rdata", line_rdata, {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                                         64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666});

        // Random traffic with random memory timing and inputs scrambled mid-burst.
        mode = 0;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            rc0 = resp_cnt;
            run_req(kind != 1, kind != 0, $urandom, rand256(), 1, cyc);
            chk("rand_resp_count", resp_cnt - rc0, (kind == 2) ? 2 : 1);
        end
        expl = m_rdata;
        chk("rand_rdata_final", line_rdata, expl);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
